cur_block_pingpong: RTL and testbench
=====================================

# cur_block_pingpong

Parametrised double-buffered current-block store for the motion-estimation datapath. It accepts a raster-ordered stream of current-frame pixels, IN_PIX per beat, and assembles them into BLK x BLK blocks in two alternating banks. It presents one complete block in parallel to the SAD array. A valid/ready write handshake and a consumer-driven `next_block` release give it back-pressure, which its fixed 8x8, free-running predecessor lacked.

## Interface
- BLK, 8: block edge in pixels; power of two, 4..32.
- PIX_W, 8: bits per pixel.
- IN_PIX, 4: pixels per input beat; power of two, divides BLK.
- Derived: BEATS = BLK*BLK/IN_PIX (beats per block); IDX_W = clog2(BEATS).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_data  in  IN_PIX*PIX_W  pixel beat; pixel 0 in bits [PIX_W-1:0].
- in_ready  out  1  write bank can accept a beat.
- next_block  in  1  consumer done with the presented block; one-cycle pulse.
- out_valid  out  1  presented block is complete.
- out_block  out  BLK*BLK*PIX_W  presented block; pixel k = row*BLK+col at [k*PIX_W +: PIX_W].
- handoff_busy  out  1  row-staggered switchover in progress. Tied 0 without CUR_ROW_STAGGER_EN.

## Operation
- Bank state:
  - Two banks, each with a `full` flag.
  - Pointers `wr_bank` and `rd_bank`, plus a beat counter `wr_idx` (IDX_W bits).
- Write side:
  - in_ready = !full[wr_bank].
  - An accepted beat (in_valid && in_ready) writes pixels wr_idx*IN_PIX .. +IN_PIX-1 of bank wr_bank.
  - wr_idx then increments.
  - On beat BEATS-1: wr_idx wraps to 0, full[wr_bank] is set, and wr_bank toggles.
- Read side:
  - out_valid = full[rd_bank]; out_block is driven from bank rd_bank.
  - next_block with out_valid=1: rd_bank toggles, and the old bank is released (full cleared) per Configuration.
  - next_block with out_valid=0: ignored, no state change.
- Simultaneous events:
  - Release and the final write beat of the other bank in the same cycle are both honoured.
  - In that case out_valid stays 1 across the switch.
  - Release of the bank wr_bank points at raises in_ready on the next cycle.
  - A write to a bank never overlaps a read of the same bank, because `full` gates both sides.
- No data reordering; in_data is stored bit-exact.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, handoff_busy=0.
  - out_block=0 (both banks cleared), wr_bank=rd_bank=0, wr_idx=0.
- Reset mid-block discards partial and full contents; no residue after reset.
- Write latency: the last beat is accepted at edge t. If rd_bank equals that bank, out_valid=1 and out_block is complete after t.
- Release to new data:
  - next_block at edge t switches rd_bank after t.
  - out_valid after t equals the full flag of the other bank.
- Throughput: one beat per cycle sustained, with no bubble at bank switch as long as the consumer releases in time.
- Minimum block period = BEATS cycles.

## Configuration
- Macro: CUR_ROW_STAGGER_EN.
- Defined (row-staggered handoff):
  - After an accepted next_block at edge t, out_block row r is sourced from the new bank from edge t+r onward (r = 0..BLK-1).
  - Rows not yet switched are sourced from the old bank.
  - handoff_busy=1 for edges t+1 .. t+BLK-1.
  - The old bank's full flag clears at edge t+BLK-1, so it cannot be rewritten while still being read.
  - next_block during handoff_busy is ignored.
  - out_valid during handoff = full flag of the new bank.
- Undefined:
  - All rows switch at edge t and the old bank is released at edge t.
  - handoff_busy is held 0.

## Test plan
- Reset then 2*BEATS beats of incrementing pixels (0,1,2..), no next_block -> out_valid after BEATS beats, pixel k = k mod 2^PIX_W. in_ready drops after the second block fills.
- With both banks full, pulse next_block -> in_ready=1 next cycle and out_block = second block. Without the macro, bank 0 is refilled on the next beats.
- next_block while out_valid=0 -> no change to rd_bank, out_block or in_ready.
- next_block on the same edge as the final beat of the other bank -> out_valid stays 1 and out_block switches to the new block in one cycle.
- With CUR_ROW_STAGGER_EN and BLK=8, release at edge t -> at edge t+3 rows 0..3 come from the new block and rows 4..7 from the old. handoff_busy=1 at edges t+1..t+7. in_ready stays 0 until after t+7, and a second next_block at t+2 is ignored.
- Assert rst mid-fill (wr_idx=5) -> all outputs return to reset values. The next block fills from beat 0 with no stale pixels.

Source files
------------

// File: rtl/cur_block_pingpong.sv
// Double-buffered BLK x BLK current-block store with valid/ready writes and consumer release.
// Optional row-staggered handoff between banks is enabled by defining CUR_ROW_STAGGER_EN.
module cur_block_pingpong #(
    parameter int unsigned BLK    = 8,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned IN_PIX = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    input  logic [IN_PIX*PIX_W-1:0]    in_data_i,
    output logic                       in_ready_o,
    input  logic                       next_block_i,
    output logic                       out_valid_o,
    output logic [BLK*BLK*PIX_W-1:0]   out_block_o,
    output logic                       handoff_busy_o
);

    localparam int unsigned BEATS  = BLK * BLK / IN_PIX;
    localparam int unsigned IDX_W  = $clog2(BEATS);
    localparam int unsigned BEAT_W = IN_PIX * PIX_W;
    localparam int unsigned ROW_W  = BLK * PIX_W;
    localparam int unsigned BLK_W  = BLK * ROW_W;

    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [BLK_W-1:0] bank_q [2];

    logic wr_fire_c;
    logic last_beat_c;
    logic release_c;

`ifdef CUR_ROW_STAGGER_EN
    localparam int unsigned ROW_IDX_W = $clog2(BLK);

    logic                 busy_q, busy_d;
    logic [ROW_IDX_W-1:0] row_cnt_q, row_cnt_d;
`endif

    assign wr_fire_c   = in_valid_i && !full_q[wr_bank_q];
    assign last_beat_c = (wr_idx_q == IDX_W'(BEATS - 1));
`ifdef CUR_ROW_STAGGER_EN
    assign release_c   = next_block_i && full_q[rd_bank_q] && !busy_q;
`else
    assign release_c   = next_block_i && full_q[rd_bank_q];
`endif

    // Bank pointers, full flags and handoff progress
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
`ifdef CUR_ROW_STAGGER_EN
        busy_d    = busy_q;
        row_cnt_d = row_cnt_q;
`endif
        if (wr_fire_c) begin
            if (last_beat_c) begin
                wr_idx_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end else begin
                wr_idx_d = wr_idx_q + IDX_W'(1);
            end
        end
        if (release_c) begin
            rd_bank_d = !rd_bank_q;
        end
`ifdef CUR_ROW_STAGGER_EN
        // Old bank stays full until its last row has been handed over.
        if (release_c) begin
            busy_d    = 1'b1;
            row_cnt_d = '0;
        end else if (busy_q) begin
            row_cnt_d = row_cnt_q + ROW_IDX_W'(1);
            if (row_cnt_q == ROW_IDX_W'(BLK - 2)) begin
                busy_d              = 1'b0;
                full_d[!rd_bank_q]  = 1'b0;
            end
        end
`else
        if (release_c) begin
            full_d[rd_bank_q] = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= '0;
`ifdef CUR_ROW_STAGGER_EN
            busy_q    <= 1'b0;
            row_cnt_q <= '0;
`endif
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
`ifdef CUR_ROW_STAGGER_EN
            busy_q    <= busy_d;
            row_cnt_q <= row_cnt_d;
`endif
        end
    end

    // Pixel storage; reset clears both banks so no stale pixels survive
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
        end else if (wr_fire_c) begin
            for (int b = 0; b < int'(BEATS); b++) begin
                if (wr_idx_q == IDX_W'(b)) begin
                    bank_q[wr_bank_q][b*BEAT_W +: BEAT_W] <= in_data_i;
                end
            end
        end
    end

    // Row-wise output mux; unswitched rows read the old bank during a handoff
    always_comb begin
        logic src;
        out_block_o = '0;
        for (int r = 0; r < int'(BLK); r++) begin
            src = rd_bank_q;
`ifdef CUR_ROW_STAGGER_EN
            if (busy_q && (ROW_IDX_W'(r) > row_cnt_q)) begin
                src = !rd_bank_q;
            end
`endif
            out_block_o[r*ROW_W +: ROW_W] = bank_q[src][r*ROW_W +: ROW_W];
        end
    end

    assign in_ready_o  = !full_q[wr_bank_q];
    assign out_valid_o = full_q[rd_bank_q];
`ifdef CUR_ROW_STAGGER_EN
    assign handoff_busy_o = busy_q;
`else
    assign handoff_busy_o = 1'b0;
`endif

endmodule

// File: tb/tb_cur_block_pingpong.sv
// Directed bench for cur_block_pingpong: vector table plus hand-written corner sequences.
module tb_cur_block_pingpong;

    localparam int BLK    = 8;
    localparam int PIX_W  = 8;
    localparam int IN_PIX = 4;
    localparam int BEATS  = BLK * BLK / IN_PIX;
    localparam int BEAT_W = IN_PIX * PIX_W;
    localparam int BLK_W  = BLK * BLK * PIX_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [BEAT_W-1:0] in_data;
    logic              in_ready;
    logic              next_block;
    logic              out_valid;
    logic [BLK_W-1:0]  out_block;
    logic              handoff_busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic v;
        int   base;
        logic nb;
        logic er;
        logic ev;
        logic eb;
        int   eblk;
    } vec_t;

    vec_t tbl [64];
    int   n_vec;

    cur_block_pingpong #(.BLK(BLK), .PIX_W(PIX_W), .IN_PIX(IN_PIX)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid_i    (in_valid),
        .in_data_i     (in_data),
        .in_ready_o    (in_ready),
        .next_block_i  (next_block),
        .out_valid_o   (out_valid),
        .out_block_o   (out_block),
        .handoff_busy_o(handoff_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [BEAT_W-1:0] beat(int base);
        logic [BEAT_W-1:0] b;
        for (int j = 0; j < IN_PIX; j++) b[j*PIX_W +: PIX_W] = PIX_W'(base + j);
        return b;
    endfunction

    // Expected block: rows below rows_new hold nbase+k, the rest obase+k
    function automatic logic [BLK_W-1:0] blk(int nbase, int rows_new, int obase);
        logic [BLK_W-1:0] b;
        for (int k = 0; k < BLK * BLK; k++) begin
            int v;
            v = ((k / BLK) < rows_new) ? nbase + k : obase + k;
            b[k*PIX_W +: PIX_W] = PIX_W'(v);
        end
        return b;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input int base, input logic nb);
        in_valid   = v;
        in_data    = beat(base);
        next_block = nb;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        next_block = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk1({tag, " ready"}, in_ready, 1'b1);
        chk1({tag, " valid"}, out_valid, 1'b0);
        chk1({tag, " busy"}, handoff_busy, 1'b0);
        chkb({tag, " block"}, out_block, '0);
    endtask

    initial begin
        // Two back-to-back blocks of incrementing pixels, then a refused beat
        for (int i = 0; i < 2 * BEATS; i++) begin
            tbl[i] = '{1'b1, 4 * i, 1'b0, (i != 2 * BEATS - 1), (i >= BEATS - 1), 1'b0,
                       (i >= BEATS - 1) ? 0 : -1};
        end
        tbl[32] = '{1'b1, 200, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        n_vec = 33;
`ifndef CUR_ROW_STAGGER_EN
        tbl[33] = '{1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 64};
        for (int j = 0; j < BEATS; j++) begin
            tbl[34 + j] = '{1'b1, 128 + 4 * j, 1'b0, (j != BEATS - 1), 1'b1, 1'b0, 64};
        end
        n_vec = 50;
`endif

        rst        = 1'b1;
        in_valid   = 1'b0;
        next_block = 1'b0;
        in_data    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_state("reset");

        for (int i = 0; i < n_vec; i++) begin
            step(tbl[i].v, tbl[i].base, tbl[i].nb);
            chk1($sformatf("vec%0d ready", i), in_ready, tbl[i].er);
            chk1($sformatf("vec%0d valid", i), out_valid, tbl[i].ev);
            chk1($sformatf("vec%0d busy", i), handoff_busy, tbl[i].eb);
            if (tbl[i].eblk >= 0)
                chkb($sformatf("vec%0d block", i), out_block, blk(tbl[i].eblk, BLK, 0));
        end

`ifndef CUR_ROW_STAGGER_EN
        // Release bank 1, then refill it and release on the same edge as its last beat
        step(1'b0, 0, 1'b1);
        chk1("rel ready", in_ready, 1'b1);
        chk1("rel valid", out_valid, 1'b1);
        chkb("rel block", out_block, blk(128, BLK, 0));
        for (int j = 0; j < BEATS - 1; j++) step(1'b1, 192 + 4 * j, 1'b0);
        chk1("pre-sim valid", out_valid, 1'b1);
        chkb("pre-sim block", out_block, blk(128, BLK, 0));
        step(1'b1, 192 + 4 * (BEATS - 1), 1'b1);
        chk1("sim valid", out_valid, 1'b1);
        chkb("sim block", out_block, blk(192, BLK, 0));
        chk1("sim ready", in_ready, 1'b1);
`else
        // Row-staggered handoff from bank 0 (pixels 0..) to bank 1 (pixels 64..)
        step(1'b0, 0, 1'b1);
        chk1("hs t busy", handoff_busy, 1'b1);
        chk1("hs t ready", in_ready, 1'b0);
        chk1("hs t valid", out_valid, 1'b1);
        chkb("hs t block", out_block, blk(64, 1, 0));
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b1);
        chkb("hs t+2 block", out_block, blk(64, 3, 0));
        step(1'b0, 0, 1'b0);
        chk1("hs t+3 busy", handoff_busy, 1'b1);
        chk1("hs t+3 ready", in_ready, 1'b0);
        chkb("hs t+3 block", out_block, blk(64, 4, 0));
        repeat (3) step(1'b0, 0, 1'b0);
        chk1("hs t+6 busy", handoff_busy, 1'b1);
        chk1("hs t+6 ready", in_ready, 1'b0);
        chkb("hs t+6 block", out_block, blk(64, 7, 0));
        step(1'b0, 0, 1'b0);
        chk1("hs t+7 busy", handoff_busy, 1'b0);
        chk1("hs t+7 ready", in_ready, 1'b1);
        chk1("hs t+7 valid", out_valid, 1'b1);
        chkb("hs t+7 block", out_block, blk(64, BLK, 0));
        step(1'b0, 0, 1'b0);
        chk1("hs t+8 valid", out_valid, 1'b1);
        chk1("hs t+8 busy", handoff_busy, 1'b0);
`endif

        // Reset after five beats of a partial block
        for (int j = 0; j < 5; j++) step(1'b1, 100 + 4 * j, 1'b0);
        rst = 1'b1;
        step(1'b0, 0, 1'b0);
        rst = 1'b0;
        chk_reset_state("midrst");

        step(1'b0, 0, 1'b1);
        chk1("nb-idle valid", out_valid, 1'b0);
        chk1("nb-idle ready", in_ready, 1'b1);
        chkb("nb-idle block", out_block, '0);

        for (int j = 0; j < BEATS - 1; j++) step(1'b1, 32 + 4 * j, 1'b0);
        chk1("refill early valid", out_valid, 1'b0);
        step(1'b1, 32 + 4 * (BEATS - 1), 1'b0);
        chk1("refill valid", out_valid, 1'b1);
        chk1("refill ready", in_ready, 1'b1);
        chkb("refill block", out_block, blk(32, BLK, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
